// File: rtl/apb_delay_calibrator.sv
// APB pass-through that stretches each access so the CPU observes device
// latency scaled by a run-time CPU/device frequency ratio r. cfg_ratio holds
// (r-1)*2^S_SHIFT; the fractional remainder carries across transfers so the
// long-run average latency is exact for non-integer r.
// Ports:
//   clock, reset          : clock, asynchronous active-high reset
//   in_*                  : upstream APB (CPU side) request in, response out
//   out_*                 : downstream APB (device side) request out, response in
//   cfg_ratio, cfg_bypass : ratio in fixed point, pure pass-through select
//   perf_clear            : synchronous clear of perf counters
//   perf_txn, perf_delay  : completed upstream transfers, cycles spent in DELAY
module apb_delay_calibrator #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned S_SHIFT = 8,
  parameter int unsigned RATIO_W = 16,
  parameter int unsigned ACC_W   = 40,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   in_paddr,
  input  logic                in_psel,
  input  logic                in_penable,
  input  logic [2:0]          in_pprot,
  input  logic                in_pwrite,
  input  logic [DATA_W-1:0]   in_pwdata,
  input  logic [DATA_W/8-1:0] in_pstrb,
  output logic                in_pready,
  output logic [DATA_W-1:0]   in_prdata,
  output logic                in_pslverr,
  output logic [ADDR_W-1:0]   out_paddr,
  output logic                out_psel,
  output logic                out_penable,
  output logic [2:0]          out_pprot,
  output logic                out_pwrite,
  output logic [DATA_W-1:0]   out_pwdata,
  output logic [DATA_W/8-1:0] out_pstrb,
  input  logic                out_pready,
  input  logic [DATA_W-1:0]   out_prdata,
  input  logic                out_pslverr,
  input  logic [RATIO_W-1:0]  cfg_ratio,
  input  logic                cfg_bypass,
  input  logic                perf_clear,
  output logic [CNT_W-1:0]    perf_txn,
  output logic [CNT_W-1:0]    perf_delay
);

  localparam int unsigned DW = ACC_W - S_SHIFT;
  localparam int unsigned MW = (DW > CNT_W) ? DW : CNT_W;

  typedef enum logic [1:0] {IDLE, WAIT_DEV, DELAY} state_t;

  state_t              state, state_next;
  logic [S_SHIFT-1:0]  residue;
  logic [ACC_W-1:0]    acc;
  logic [RATIO_W-1:0]  ratio_q;
  logic                bypass_q;   // bypass transfer is open, mode held until it completes
  logic [CNT_W-1:0]    counter;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  logic                access;
  logic                byp;
  logic [RATIO_W-1:0]  ratio_sel;
  logic [ACC_W-1:0]    base;
  logic [ACC_W:0]      sum;
  logic [ACC_W-1:0]    acc_cur;
  logic [MW-1:0]       d_wide;
  logic [CNT_W-1:0]    d_sat;
  logic                acc_load, res_load, delay_load;

  // Request side always mirrors upstream except psel/penable in DELAY
  assign out_paddr  = in_paddr;
  assign out_pprot  = in_pprot;
  assign out_pwrite = in_pwrite;
  assign out_pwdata = in_pwdata;
  assign out_pstrb  = in_pstrb;

  // Accumulator arithmetic: the first access cycle starts from residue with the live ratio
  assign access    = in_psel & in_penable;
  assign byp       = (state == IDLE) & (bypass_q | cfg_bypass);
  assign ratio_sel = (state == IDLE) ? cfg_ratio : ratio_q;
  assign base      = (state == IDLE) ? ACC_W'(residue) : acc;
  assign sum       = {1'b0, base} + (ACC_W+1)'(ratio_sel);
  assign acc_cur   = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  assign d_wide    = MW'(acc_cur[ACC_W-1:S_SHIFT]);
  assign d_sat     = (d_wide > MW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : CNT_W'(d_wide);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state, upstream response and datapath load strobes
  always_comb begin
    state_next  = state;
    in_pready   = 1'b0;
    in_prdata   = '0;
    in_pslverr  = 1'b0;
    out_psel    = in_psel;
    out_penable = in_penable;
    acc_load    = 1'b0;
    res_load    = 1'b0;
    delay_load  = 1'b0;
    case (state)
      IDLE, WAIT_DEV: begin
        if (byp) begin
          in_pready  = out_pready;
          in_prdata  = out_prdata;
          in_pslverr = out_pslverr;
        end else if (access) begin
          if (!out_pready) begin
            acc_load   = 1'b1;
            state_next = WAIT_DEV;
          end else begin
            res_load = 1'b1;
            if (d_sat == '0) begin
              in_pready  = 1'b1;
              in_prdata  = out_prdata;
              in_pslverr = out_pslverr;
              state_next = IDLE;
            end else begin
              delay_load = 1'b1;
              state_next = DELAY;
            end
          end
        end
      end
      DELAY: begin
        out_psel    = 1'b0;
        out_penable = 1'b0;
        in_pready   = (counter == '0);
        in_prdata   = rdata_q;
        in_pslverr  = err_q;
        if (counter == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: mode latch, accumulator, residue, delay counter, saved response
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      residue  <= '0;
      acc      <= '0;
      ratio_q  <= '0;
      bypass_q <= 1'b0;
      counter  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == IDLE && access && !bypass_q) ratio_q <= cfg_ratio;
      if (byp && access) bypass_q <= ~out_pready;
      if (acc_load) acc <= acc_cur;
      if (res_load) residue <= acc_cur[S_SHIFT-1:0];
      if (delay_load) begin
        counter <= d_sat - CNT_W'(1);
        rdata_q <= out_prdata;
        err_q   <= out_pslverr;
      end else if (state == DELAY && counter != '0) begin
        counter <= counter - CNT_W'(1);
      end
    end
  end

  // Perf counters; clear wins over a simultaneous increment
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_txn   <= '0;
      perf_delay <= '0;
    end else if (perf_clear) begin
      perf_txn   <= '0;
      perf_delay <= '0;
    end else begin
      if (access && in_pready) perf_txn   <= perf_txn + CNT_W'(1);
      if (state == DELAY)      perf_delay <= perf_delay + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_apb_delay_calibrator.sv
// Directed bench for apb_delay_calibrator: upstream master and downstream
// slave are driven from tasks; latency, data, error and psel blocking are
// checked against hand-computed values.
module tb_apb_delay_calibrator;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned RATIO_W = 16;
  localparam int unsigned CNT_W   = 32;

  logic                clock, reset;
  logic [ADDR_W-1:0]   in_paddr;
  logic                in_psel, in_penable, in_pwrite;
  logic [2:0]          in_pprot;
  logic [DATA_W-1:0]   in_pwdata;
  logic [DATA_W/8-1:0] in_pstrb;
  logic                in_pready, in_pslverr;
  logic [DATA_W-1:0]   in_prdata;
  logic [ADDR_W-1:0]   out_paddr;
  logic                out_psel, out_penable, out_pwrite;
  logic [2:0]          out_pprot;
  logic [DATA_W-1:0]   out_pwdata;
  logic [DATA_W/8-1:0] out_pstrb;
  logic                out_pready, out_pslverr;
  logic [DATA_W-1:0]   out_prdata;
  logic [RATIO_W-1:0]  cfg_ratio;
  logic                cfg_bypass, perf_clear;
  logic [CNT_W-1:0]    perf_txn, perf_delay;

  apb_delay_calibrator dut (
    .clock(clock), .reset(reset),
    .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable), .in_pprot(in_pprot),
    .in_pwrite(in_pwrite), .in_pwdata(in_pwdata), .in_pstrb(in_pstrb),
    .in_pready(in_pready), .in_prdata(in_prdata), .in_pslverr(in_pslverr),
    .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable), .out_pprot(out_pprot),
    .out_pwrite(out_pwrite), .out_pwdata(out_pwdata), .out_pstrb(out_pstrb),
    .out_pready(out_pready), .out_prdata(out_prdata), .out_pslverr(out_pslverr),
    .cfg_ratio(cfg_ratio), .cfg_bypass(cfg_bypass), .perf_clear(perf_clear),
    .perf_txn(perf_txn), .perf_delay(perf_delay)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One upstream transfer; slave becomes ready on access cycle k.
  // After the first access cycle the config is switched to ratio2/byp2.
  task automatic run_xfer(input string tag, input logic [15:0] ratio, input logic byp,
                          input int k, input logic [31:0] data, input logic err,
                          input logic [15:0] ratio2, input logic byp2,
                          input int exp_total, input logic clr);
    int n;
    int psel_bad;
    bit done;
    @(negedge clock);
    in_paddr = $urandom; in_pwrite = 1'b0; in_psel = 1'b1; in_penable = 1'b0;
    cfg_ratio = ratio; cfg_bypass = byp;
    out_pready = 1'b0; out_prdata = data; out_pslverr = err;
    @(negedge clock);
    in_penable = 1'b1;
    n = 0; psel_bad = 0; done = 1'b0;
    while (!done && n < 300) begin
      n++;
      if (n == 2) begin cfg_ratio = ratio2; cfg_bypass = byp2; end
      out_pready = (n >= k);
      if (n > k) begin out_prdata = ~data; out_pslverr = ~err; end
      #1;
      if (out_psel !== (n <= k)) psel_bad++;
      if (in_pready) begin
        done = 1'b1;
        check({tag, "_rdata"}, in_prdata, data);
        check({tag, "_slverr"}, in_pslverr, err);
        if (clr) perf_clear = 1'b1;
      end
      @(negedge clock);
    end
    check({tag, "_latency"}, n, exp_total);
    check({tag, "_psel_block"}, psel_bad, 0);
    in_psel = 1'b0; in_penable = 1'b0; out_pready = 1'b0;
    perf_clear = 1'b0; cfg_ratio = '0; cfg_bypass = 1'b0;
    if (clr) begin
      #1;
      check({tag, "_perf_txn_cleared"}, perf_txn, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_paddr = 32'h1234_5678; in_psel = 1'b1; in_penable = 1'b0; in_pprot = 3'd2;
    in_pwrite = 1'b1; in_pwdata = 32'hCAFE_F00D; in_pstrb = 4'hF;
    out_pready = 1'b1; out_prdata = 32'hDEAD_BEEF; out_pslverr = 1'b1;
    cfg_ratio = '0; cfg_bypass = 1'b0; perf_clear = 1'b0;
    #12;
    check("rst_pready", in_pready, 0);
    check("rst_prdata", in_prdata, 0);
    check("rst_pslverr", in_pslverr, 0);
    check("rst_perf_txn", perf_txn, 0);
    check("rst_perf_delay", perf_delay, 0);
    check("rst_out_psel", out_psel, 1);
    check("rst_out_penable", out_penable, 0);
    check("rst_out_paddr", out_paddr, 32'h1234_5678);
    check("rst_out_pwdata", out_pwdata, 32'hCAFE_F00D);
    @(negedge clock);
    reset = 1'b0; in_psel = 1'b0; out_pready = 1'b0; out_pslverr = 1'b0;

    // r=5, ready on first access cycle: D=4
    run_xfer("r5_k1", 16'd1024, 1'b0, 1, 32'h0000_00A1, 1'b0, 16'd1024, 1'b0, 5, 1'b0);

    // r=2.5, four single-cycle reads: D = 1,2,1,2
    @(negedge clock); perf_clear = 1'b1;
    @(negedge clock); perf_clear = 1'b0;
    run_xfer("r2p5_a", 16'd384, 1'b0, 1, 32'h1111_0001, 1'b0, 16'd384, 1'b0, 2, 1'b0);
    run_xfer("r2p5_b", 16'd384, 1'b0, 1, 32'h1111_0002, 1'b0, 16'd384, 1'b0, 3, 1'b0);
    run_xfer("r2p5_c", 16'd384, 1'b0, 1, 32'h1111_0003, 1'b0, 16'd384, 1'b0, 2, 1'b0);
    run_xfer("r2p5_d", 16'd384, 1'b0, 1, 32'h1111_0004, 1'b0, 16'd384, 1'b0, 3, 1'b0);
    check("r2p5_perf_delay", perf_delay, 6);
    check("r2p5_perf_txn", perf_txn, 4);

    // r=5, ready on 3rd cycle with error, ratio changed mid-transfer: D=12
    run_xfer("r5_k3_err", 16'd1024, 1'b0, 3, 32'h0BAD_0BAD, 1'b1, 16'd0, 1'b0, 15, 1'b0);

    // Leave residue 128, then show bypass and ratio 0 keep it intact
    run_xfer("res128", 16'd384, 1'b0, 1, 32'h2222_0001, 1'b0, 16'd384, 1'b0, 2, 1'b0);
    run_xfer("bypass", 16'd1024, 1'b1, 2, 32'h3333_0001, 1'b1, 16'd1024, 1'b0, 2, 1'b0);
    run_xfer("ratio0", 16'd0, 1'b0, 1, 32'h4444_0001, 1'b0, 16'd0, 1'b0, 1, 1'b0);
    run_xfer("res_kept", 16'd384, 1'b0, 1, 32'h5555_0001, 1'b0, 16'd384, 1'b0, 3, 1'b0);
    run_xfer("res128b", 16'd384, 1'b0, 1, 32'h6666_0001, 1'b0, 16'd384, 1'b0, 2, 1'b0);

    // Reset while in DELAY with counter=5 (D=7 from residue 128 + 1792)
    @(negedge clock);
    in_psel = 1'b1; in_penable = 1'b0; cfg_ratio = 16'd1792;
    out_pready = 1'b0; out_prdata = 32'hA5A5_A5A5; out_pslverr = 1'b1;
    @(negedge clock); in_penable = 1'b1; out_pready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    #1;
    check("dly_pready", in_pready, 0);
    check("dly_prdata_held", in_prdata, 32'hA5A5_A5A5);
    check("dly_out_psel", out_psel, 0);
    reset = 1'b1;
    #1;
    check("midrst_pready", in_pready, 0);
    check("midrst_prdata", in_prdata, 0);
    check("midrst_pslverr", in_pslverr, 0);
    check("midrst_out_psel", out_psel, 1);
    check("midrst_perf_delay", perf_delay, 0);
    @(negedge clock);
    in_psel = 1'b0; in_penable = 1'b0; out_pready = 1'b0; out_pslverr = 1'b0; cfg_ratio = '0;
    reset = 1'b0;
    run_xfer("after_rst", 16'd384, 1'b0, 1, 32'h7777_0001, 1'b0, 16'd384, 1'b0, 2, 1'b0);

    // perf_clear on the completing cycle
    run_xfer("perf_clr", 16'd1024, 1'b0, 1, 32'h8888_0001, 1'b0, 16'd1024, 1'b0, 5, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/apb_delay_calibrator.md
Name: apb_delay_calibrator

Overview:
Parametrised APB pass-through that stretches each access so the CPU sees device latency scaled by a CPU/device frequency ratio r. The ratio is a run-time input in fixed point ((r-1)*2^S_SHIFT), not a fixed constant. The fractional remainder carries across transactions, so long-run average latency is exact for non-integer r. Sits between the CPU-side APB master and one APB slave (SDRAM/UART/etc.), with bypass mode and simulation-visible perf counters.

Parameters:
ADDR_W, 32, APB address width
DATA_W, 32, APB data width (strobe width DATA_W/8)
S_SHIFT, 8, log2 of fixed-point scale s
RATIO_W, 16, width of cfg_ratio
ACC_W, 40, accumulator width (saturating)
CNT_W, 32, delay-counter and perf-counter width

Ports:
clock  in  1  clock
reset  in  1  reset, asynchronous, active-high
in_paddr/in_psel/in_penable/in_pprot/in_pwrite/in_pwdata/in_pstrb  in  ADDR_W/1/1/3/1/DATA_W/DATA_W/8  upstream APB request
in_pready/in_prdata/in_pslverr  out  1/DATA_W/1  upstream APB response
out_paddr/out_psel/out_penable/out_pprot/out_pwrite/out_pwdata/out_pstrb  out  as in_*  downstream APB request
out_pready/out_prdata/out_pslverr  in  1/DATA_W/1  downstream APB response
cfg_ratio  in  RATIO_W  (r-1)*s, unsigned
cfg_bypass  in  1  1 = pure pass-through, no delay
perf_clear  in  1  synchronous clear of perf counters
perf_txn  out  CNT_W  completed upstream transfers
perf_delay  out  CNT_W  cycles spent in DELAY

Behaviour:
- Reset state: IDLE; residue, acc, counter, saved data/err, perf counters all 0. in_pready=0, in_prdata=0, in_pslverr=0. out_* pass through in_* combinationally.
- Reset mid-transaction: abort to IDLE, drop saved response, clear residue. No pready is issued for the aborted transfer.
- out_paddr/pprot/pwrite/pwdata/pstrb always equal in_*. out_psel and out_penable equal in_* except in DELAY, where they are forced to 0 (no re-issue to device).
- Access cycle = in_psel & in_penable. Setup-phase cycles pass through and are not counted.
- Mode latch: on the first access cycle in IDLE, cfg_ratio and cfg_bypass are sampled into ratio_q and bypass_q, held until the transfer completes. Config changes mid-transfer are ignored.
- Bypass (sampled 1): in_pready/in_prdata/in_pslverr = out_* combinationally. Residue untouched. FSM stays IDLE.
- Per access cycle: acc_cur = (IDLE ? residue : acc) + ratio. The first cycle uses cfg_ratio; later cycles use ratio_q. Saturate at 2^ACC_W-1.
- If out_pready=0: acc <= acc_cur; state -> WAIT_DEV.
- If out_pready=1: D = acc_cur >> S_SHIFT (saturated to CNT_W); residue <= acc_cur[S_SHIFT-1:0].
  - D==0: in_pready/prdata/pslverr = out_* combinationally in the same cycle; state -> IDLE.
  - D>0: latch prdata/pslverr; counter <= D-1; state -> DELAY.
- DELAY: in_pready = (counter==0); in_prdata/in_pslverr = saved values (held stable). counter decrements each cycle. At counter==0, state -> IDLE next cycle.
- Timing: device ready on access cycle k gives an upstream access phase of exactly k + D cycles, D = floor((residue_prev + k*ratio)/s).
- in_pready is 0 in all other states/cycles. Error responses are delayed identically.
- perf_txn +1 on every cycle with in_psel&in_penable&in_pready. perf_delay +1 on every cycle in DELAY.
- Perf counters wrap. perf_clear wins over a simultaneous increment.

Test Plan:
- ratio=1024 (r=5), slave ready on 1st access cycle -> D=4, in_pready high on 5th access cycle, prdata=slave data, residue 0, out_psel low during the 4 DELAY cycles.
- ratio=384 (r=2.5), four back-to-back single-cycle reads -> D sequence 1,2,1,2; residue 128,0,128,0; perf_delay=6, perf_txn=4.
- ratio=1024, slave ready on 3rd access cycle with pslverr=1 -> D=12, upstream sees pready+pslverr on access cycle 15.
- ratio=0, or cfg_bypass=1 -> in_pready combinationally equals out_pready on the same cycle, prdata identical. Changing cfg_ratio mid-transfer has no effect on D.
- Assert reset with counter=5 in DELAY -> in_pready/in_prdata/in_pslverr immediately 0, state IDLE, residue 0. The next transfer is timed from scratch.
- perf_clear asserted in the same cycle as a completing transfer -> perf_txn=0 next cycle.
